// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage: fixed-latency mult/div,
// mthi/mtlo writes, mfhi/mflo read data and the HI/LO hazard stall.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  input  logic        d_use_hl,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        proto_err
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e      state, state_nxt;
  md_op_e      op_e;
  logic [3:0]  cnt;
  logic [31:0] hi_pend, lo_pend;
  logic        pend_ok;
  logic        is_mul, is_div, is_md, is_mt, last;

  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag;
  logic [63:0] result;
  logic        result_ok;

  assign op_e   = md_op_e'(op);
  assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign is_div = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  assign is_md  = is_mul || is_div;
  assign is_mt  = (op_e == OP_MTHI) || (op_e == OP_MTLO);
  assign last   = (cnt == 4'd1);

  // One 64-bit multiplier serves both signednesses: sign- or zero-extend
  // the operands and keep the low 64 bits of the product.
  always_comb begin
    mul_a = (op_e == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b = (op_e == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = mul_a * mul_b;
  end

  // Signed division runs on magnitudes, so min/-1 needs no special case;
  // a zero divisor is replaced to keep the divider defined, result dropped.
  always_comb begin
    a_mag = ((op_e == OP_DIV) && a[31]) ? -a : a;
    b_mag = ((op_e == OP_DIV) && b[31]) ? -b : b;
    div_b = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
  end

  always_comb begin
    result    = '0;
    result_ok = 1'b1;
    case (op_e)
      OP_MULT, OP_MULTU: result = prod;
      OP_DIV:  result = {(a[31] ? -r_mag : r_mag),
                         ((a[31] ^ b[31]) ? -q_mag : q_mag)};
      OP_DIVU: result = {r_mag, q_mag};
      default: ;
    endcase
    if (is_div && (b == '0)) result_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && is_md) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= '0;
      lo        <= '0;
      hi_pend   <= '0;
      lo_pend   <= '0;
      pend_ok   <= 1'b0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_md) begin
            hi_pend <= result[63:32];
            lo_pend <= result[31:0];
            pend_ok <= result_ok;
            cnt     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end else if (start && (op_e == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op_e == OP_MTLO)) begin
            lo <= a;
          end
        end
        S_RUN: begin
          cnt <= cnt - 4'd1;
          if (last && pend_ok) begin
            hi <= hi_pend;
            lo <= lo_pend;
          end
          if (start && (is_md || is_mt)) proto_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == S_RUN);
  assign stall = d_use_hl & (busy | (start & is_md));
  assign rdata = rd_hi ? hi : lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus random traffic
// against a cycle-count reference model of HI/LO behaviour.
module tb_md_sequencer;

  localparam int N_MUL = 5;
  localparam int N_DIV = 10;
  localparam logic [2:0] C_NONE = 3'd0, C_MULT = 3'd1, C_MULTU = 3'd2,
                         C_DIV = 3'd3, C_DIVU = 3'd4, C_MTHI = 3'd5,
                         C_MTLO = 3'd6, C_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rd_hi, d_use_hl;
  logic [31:0] rdata, hi, lo;
  logic        busy, stall, proto_err;

  int errors = 0;
  int checks = 0;
  int busy_seen, stall_seen;

  // reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pok, m_perr;
  int          m_left;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_hi(rd_hi), .d_use_hl(d_use_hl), .rdata(rdata), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void md_compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rhi, output logic [31:0] rlo, output bit ok);
    longint sx, sy, q, r, p;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    ok = 1'b1;
    rhi = '0;
    rlo = '0;
    case (o)
      C_MULT:  begin p = sx * sy; rhi = p[63:32]; rlo = p[31:0]; end
      C_MULTU: begin up = ux * uy; rhi = up[63:32]; rlo = up[31:0]; end
      C_DIV: begin
        if (y == 0) ok = 1'b0;
        else begin q = sx / sy; r = sx % sy; rlo = q[31:0]; rhi = r[31:0]; end
      end
      C_DIVU: begin
        if (y == 0) ok = 1'b0;
        else begin rlo = x / y; rhi = x % y; end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    m_pok = 1'b0; m_perr = 1'b0; m_left = 0;
  endfunction

  function automatic void model_edge();
    if (m_left > 0) begin
      if (start && op >= C_MULT && op <= C_MTLO) m_perr = 1'b1;
      m_left--;
      if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (start) begin
      if (op >= C_MULT && op <= C_DIVU) begin
        md_compute(op, a, b, m_phi, m_plo, m_pok);
        m_left = (op <= C_MULTU) ? N_MUL : N_DIV;
      end else if (op == C_MTHI) m_hi = a;
      else if (op == C_MTLO) m_lo = a;
    end
  endfunction

  task automatic check_outputs();
    bit exp_stall;
    exp_stall = d_use_hl && ((m_left > 0) || (start && op >= C_MULT && op <= C_DIVU));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("stall", 32'(stall), 32'(exp_stall));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("rdata", rdata, rd_hi ? m_hi : m_lo);
    check("proto_err", 32'(proto_err), 32'(m_perr));
  endtask

  // one clock cycle: drive at negedge, check mid-low-phase, model at posedge
  task automatic cycle(input bit s, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input bit rh, input bit du);
    start = s; op = o; a = av; b = bv; rd_hi = rh; d_use_hl = du;
    #1;
    check_outputs();
    busy_seen  += int'(busy);
    stall_seen += int'(stall);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rh, input bit du);
    for (int i = 0; i < n; i++) cycle(1'b0, C_NONE, '0, '0, rh, du);
  endtask

  task automatic do_reset();
    start = 1'b0; op = C_NONE;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_perr", 32'(proto_err), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = C_NONE; a = '0; b = '0;
    rd_hi = 1'b0; d_use_hl = 1'b0;
    #1;
    model_reset();
    check("por_hi", hi, 32'h0);
    check("por_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // mult -3 * 5
    busy_seen = 0;
    cycle(1'b1, C_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    idle(N_MUL + 1, 1'b0, 1'b0);
    check("mult_busy_len", 32'(busy_seen), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_rdata_lo", rdata, 32'hFFFF_FFF1);

    // divu 0xFFFFFFFF / 16
    busy_seen = 0;
    cycle(1'b1, C_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b0);
    idle(N_DIV + 1, 1'b1, 1'b0);
    check("divu_busy_len", 32'(busy_seen), 32'd10);
    check("divu_lo", lo, 32'h0FFF_FFFF);
    check("divu_hi", hi, 32'h0000_000F);

    // div -7 / 2 and min / -1
    cycle(1'b1, C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(N_DIV, 1'b0, 1'b0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(N_DIV, 1'b0, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    // stall with d_use_hl held, then without
    stall_seen = 0;
    cycle(1'b1, C_MULTU, 32'd7, 32'd9, 1'b0, 1'b1);
    idle(N_MUL + 1, 1'b0, 1'b1);
    check("multu_stall_len", 32'(stall_seen), 32'd6);
    check("multu_stall_after", 32'(stall), 32'h0);
    stall_seen = 0;
    cycle(1'b1, C_MULTU, 32'd7, 32'd9, 1'b0, 1'b0);
    idle(N_MUL + 1, 1'b0, 1'b0);
    check("multu_nostall", 32'(stall_seen), 32'd0);

    // mthi in idle; mtlo during a div is rejected
    busy_seen = 0;
    cycle(1'b1, C_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, C_NONE, '0, '0, 1'b1, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_nobusy", 32'(busy_seen), 32'd0);
    cycle(1'b1, C_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    cycle(1'b1, C_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    idle(N_DIV, 1'b0, 1'b0);
    check("mtlo_ignored_lo", lo, 32'd14);
    check("mtlo_perr", 32'(proto_err), 32'h1);
    do_reset();

    // divide by zero leaves HI/LO untouched
    cycle(1'b1, C_MTHI, 32'hA, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, C_MTLO, 32'hB, 32'd0, 1'b0, 1'b0);
    busy_seen = 0;
    cycle(1'b1, C_DIV, 32'd55, 32'd0, 1'b0, 1'b0);
    idle(N_DIV + 1, 1'b0, 1'b0);
    check("div0_busy_len", 32'(busy_seen), 32'd10);
    check("div0_hi", hi, 32'hA);
    check("div0_lo", lo, 32'hB);

    // reset in busy cycle 3 of a mult, then a fresh mult
    cycle(1'b1, C_MULT, 32'd1000, 32'd1000, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    do_reset();
    busy_seen = 0;
    cycle(1'b1, C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(N_MUL + 1, 1'b0, 1'b0);
    check("post_rst_busy_len", 32'(busy_seen), 32'd5);
    check("post_rst_lo", lo, 32'h1);
    check("post_rst_hi", hi, 32'h0);

    // random traffic, including commands issued while busy
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 2) == 0), rop, rand_operand(), rand_operand(),
            1'($urandom), 1'($urandom));
      if (i == 300) do_reset();
    end
    idle(N_DIV + 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
